// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port instruction/data RAM between the instruction fetch
// requester and the data load/store requester. One requester is granted at a
// time. The RAM address, enables and write data are registered and held for
// the whole access. Completion is signalled with a one-cycle ready pulse on
// the granted side.
//
// Access sequence: IDLE -> ACCESS (RAM_LATENCY cycles) -> RESP (1 cycle) -> IDLE
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   undefined : DATA always beats FETCH when both are pending in IDLE.
//   defined   : a contended grant goes to the side not granted last.
//               The last-grant flag resets to DATA.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   i_req/i_addr        fetch request (held until i_ready) and PC address
//   i_ready/i_data      fetch done pulse; registered instruction word
//   d_read/d_write      load/store request (held until d_ready); both = store
//   d_addr/d_wdata      data address and store data
//   d_ready/d_rdata     data done pulse; registered load data
//   ram_addr/ram_ren/
//   ram_wen/ram_wdata   registered RAM controls
//   ram_rdata           RAM read data
//   busy                high while in ACCESS or RESP
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int RAM_LATENCY = 2    // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    G_FETCH = 1'b0,
    G_DATA  = 1'b1
  } grant_t;

  state_t             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  grant_t             grant_q,     grant_d;
  logic               store_q,     store_d;
  logic [ADDR_W-1:0]  ram_addr_q,  ram_addr_d;
  logic               ram_ren_q,   ram_ren_d;
  logic               ram_wen_q,   ram_wen_d;
  logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]  i_data_q,    i_data_d;
  logic [DATA_W-1:0]  d_rdata_q,   d_rdata_d;
  logic               i_ready_q,   i_ready_d;
  logic               d_ready_q,   d_ready_d;

  logic d_pending;
  logic pick_data;

  assign d_pending = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  grant_t last_q, last_d;

  // Under contention, alternate away from whoever was served last.
  always_comb begin
    if (d_pending && i_req) pick_data = (last_q == G_FETCH);
    else                    pick_data = d_pending;
  end
`else
  // Fixed priority: the core is stalled on data, so data must not starve.
  always_comb begin
    pick_data = d_pending;
  end
`endif

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    store_d     = store_q;
    ram_addr_d  = ram_addr_q;
    ram_ren_d   = ram_ren_q;
    ram_wen_d   = ram_wen_q;
    ram_wdata_d = ram_wdata_q;
    i_data_d    = i_data_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_req || d_pending) begin
          cnt_d   = CNT_W'(RAM_LATENCY - 1);
          state_d = S_ACCESS;
          if (pick_data) begin
            grant_d    = G_DATA;
            ram_addr_d = d_addr;
            // A simultaneous read+write is treated as a store.
            store_d    = d_write;
            ram_wen_d  = d_write;
            ram_ren_d  = ~d_write;
            if (d_write) ram_wdata_d = d_wdata;
          end else begin
            grant_d    = G_FETCH;
            ram_addr_d = i_addr;
            store_d    = 1'b0;
            ram_wen_d  = 1'b0;
            ram_ren_d  = 1'b1;
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d = pick_data ? G_DATA : G_FETCH;
`endif
        end
      end

      S_ACCESS: begin
        // Requester inputs are not looked at here: the grant is committed.
        if (cnt_q == '0) begin
          if (grant_q == G_FETCH)  i_data_d  = ram_rdata;
          else if (!store_q)       d_rdata_d = ram_rdata;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          i_ready_d = (grant_q == G_FETCH);
          d_ready_d = (grant_q == G_DATA);
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_RESP: begin
        // Ready is high for this one cycle; the extra IDLE cycle that follows
        // lets the requester drop its request before it could be re-granted.
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      grant_q     <= G_FETCH;
      store_q     <= 1'b0;
      ram_addr_q  <= '0;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_wdata_q <= '0;
      i_data_q    <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q      <= G_DATA;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      store_q     <= store_d;
      ram_addr_q  <= ram_addr_d;
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      ram_wdata_q <= ram_wdata_d;
      i_data_q    <= i_data_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_data    = i_data_q;
  assign d_rdata   = d_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_ren   = ram_ren_q;
  assign ram_wen   = ram_wen_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter (RAM_LATENCY = 2). A behavioural
// RAM returns valid data only once address/enable have been stable for
// RAM_LATENCY cycles. The reference model predicts, per transaction, who is
// served first, the clock cycle on which each ready pulses and the data
// returned, from the arbitration rules and a shadow copy of the memory.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int LAT    = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [DATA_W-1:0] i_data;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_ren;
  logic              ram_wen;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  mem_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .RAM_LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ready   (i_ready),
    .i_data    (i_data),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .ram_addr  (ram_addr),
    .ram_ren   (ram_ren),
    .ram_wen   (ram_wen),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: data is only correct after LAT cycles of stable enable.
  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int age = 0;

  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr] <= ram_wdata;
    if (ram_ren || ram_wen) age <= age + 1;
    else                    age <= 0;
  end

  assign ram_rdata = (ram_ren && age >= LAT - 1) ? mem[ram_addr] : ~mem[ram_addr];

  // Reference model state
  logic [DATA_W-1:0] exp_i_data;
  logic [DATA_W-1:0] exp_d_rdata;
  bit                last_data;   // 1: last grant went to DATA

  int n_tests = 0;
  int n_fail  = 0;

  function automatic bit rr_enabled();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    exp_i_data  = '0;
    exp_d_rdata = '0;
    last_data   = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    n_tests++;
    if ({i_ready, d_ready, ram_ren, ram_wen, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000", {i_ready, d_ready, ram_ren, ram_wen, busy});
    end
    n_tests++;
    if (ram_addr !== '0 || ram_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_ram_bus: addr %h wdata %h want 0", ram_addr, ram_wdata);
    end
    n_tests++;
    if (i_data !== '0 || d_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_data: i_data %h d_rdata %h want 0", i_data, d_rdata);
    end
    rst = 1'b0;
  endtask

  // Single access, checked cycle by cycle on the RAM side and the ready side.
  task automatic directed_access(input string name, input bit is_fetch, input bit dr,
                                 input bit dw, input logic [ADDR_W-1:0] a,
                                 input logic [DATA_W-1:0] wd);
    int s;
    bit st, in_acc, rdy;
    st = !is_fetch && dw;
    s  = cyc + 1;
    if (is_fetch)  exp_i_data  = ref_mem[a];
    else if (st)   ref_mem[a]  = wd;
    else           exp_d_rdata = ref_mem[a];
    last_data = !is_fetch;
    i_req   = is_fetch;
    i_addr  = a;
    d_read  = !is_fetch && dr;
    d_write = !is_fetch && dw;
    d_addr  = a;
    d_wdata = wd;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      in_acc = (cyc >= s) && (cyc < s + LAT);
      rdy    = (cyc == s + LAT);
      n_tests++;
      if (ram_ren !== (in_acc && !st) || ram_wen !== (in_acc && st)) begin
        n_fail++;
        $display("FAIL %s_enables cyc+%0d: ren %b wen %b want %b %b",
                 name, cyc - s, ram_ren, ram_wen, in_acc && !st, in_acc && st);
      end
      if (in_acc) begin
        n_tests++;
        if (ram_addr !== a || (st && ram_wdata !== wd)) begin
          n_fail++;
          $display("FAIL %s_bus cyc+%0d: addr %h wdata %h want %h %h",
                   name, cyc - s, ram_addr, ram_wdata, a, wd);
        end
      end
      n_tests++;
      if (busy !== ((cyc >= s) && (cyc <= s + LAT))) begin
        n_fail++;
        $display("FAIL %s_busy cyc+%0d: got %b", name, cyc - s, busy);
      end
      n_tests++;
      if (i_ready !== (rdy && is_fetch) || d_ready !== (rdy && !is_fetch)) begin
        n_fail++;
        $display("FAIL %s_ready cyc+%0d: i %b d %b want %b %b",
                 name, cyc - s, i_ready, d_ready, rdy && is_fetch, rdy && !is_fetch);
      end
      if (rdy) begin
        n_tests++;
        if (i_data !== exp_i_data || d_rdata !== exp_d_rdata) begin
          n_fail++;
          $display("FAIL %s_data: i_data %h d_rdata %h want %h %h",
                   name, i_data, d_rdata, exp_i_data, exp_d_rdata);
        end
        i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
      end
    end
  endtask

  // One or two simultaneous requests; checks serve order, pulse cycles, data.
  task automatic run_pair(input string name, input bit do_f, input logic [ADDR_W-1:0] fa,
                          input bit do_d, input bit dr, input bit dw,
                          input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] wd);
    int s, first_t, second_t, exp_f_t, exp_d_t, got_f, got_d, nf, nd;
    bit data_first;
    s        = cyc + 1;
    first_t  = s + LAT;
    second_t = s + 2 * LAT + 2;
    if (do_f && do_d) data_first = rr_enabled() ? !last_data : 1'b1;
    else              data_first = do_d;
    exp_d_t = (do_f && !data_first) ? second_t : first_t;
    exp_f_t = (do_d && data_first)  ? second_t : first_t;
    if (do_f && do_d) last_data = !data_first;
    else              last_data = do_d;
    // Data effects applied in service order against the shadow memory.
    if (do_d && data_first) begin
      if (dw) ref_mem[da] = wd; else exp_d_rdata = ref_mem[da];
    end
    if (do_f) exp_i_data = ref_mem[fa];
    if (do_d && !data_first) begin
      if (dw) ref_mem[da] = wd; else exp_d_rdata = ref_mem[da];
    end
    i_req   = do_f;
    i_addr  = fa;
    d_read  = do_d && dr;
    d_write = do_d && dw;
    d_addr  = da;
    d_wdata = wd;
    got_f = -1; got_d = -1; nf = 0; nd = 0;
    for (int k = 0; k < 2 * LAT + 6; k++) begin
      @(negedge clk);
      if (i_ready) begin
        nf++; got_f = cyc; i_req = 1'b0;
        n_tests++;
        if (i_data !== exp_i_data) begin
          n_fail++;
          $display("FAIL %s_i_data: got %h want %h", name, i_data, exp_i_data);
        end
      end
      if (d_ready) begin
        nd++; got_d = cyc; d_read = 1'b0; d_write = 1'b0;
        n_tests++;
        if (d_rdata !== exp_d_rdata) begin
          n_fail++;
          $display("FAIL %s_d_rdata: got %h want %h", name, d_rdata, exp_d_rdata);
        end
      end
    end
    n_tests++;
    if (nf != int'(do_f) || nd != int'(do_d)) begin
      n_fail++;
      $display("FAIL %s_pulses: i %0d d %0d want %0d %0d", name, nf, nd, do_f, do_d);
    end
    n_tests++;
    if ((do_f && got_f != exp_f_t) || (do_d && got_d != exp_d_t)) begin
      n_fail++;
      $display("FAIL %s_timing: i_ready@+%0d d_ready@+%0d want +%0d +%0d",
               name, got_f - s, got_d - s, exp_f_t - s, exp_d_t - s);
    end
    n_tests++;
    if (i_data !== exp_i_data || d_rdata !== exp_d_rdata || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_hold: i_data %h d_rdata %h busy %b want %h %h 0",
               name, i_data, d_rdata, busy, exp_i_data, exp_d_rdata);
    end
    i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  task automatic test_contention();
    for (int r = 0; r < 4; r++)
      run_pair("contention", 1'b1, ADDR_W'(12'h040 + 4 * r), 1'b1, 1'b1, 1'b0,
               ADDR_W'(12'h200 + 4 * r), '0);
  endtask

  task automatic test_drop_mid_access();
    int s, nr;
    logic [ADDR_W-1:0] a;
    a = 12'h0A8;
    s = cyc + 1;
    exp_i_data = ref_mem[a];
    last_data  = 1'b0;
    i_req  = 1'b1;
    i_addr = a;
    @(negedge clk);
    i_req  = 1'b0;
    i_addr = 12'h3FC;
    nr = 0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      if (i_ready) begin
        nr++;
        n_tests++;
        if (cyc != s + LAT || i_data !== exp_i_data) begin
          n_fail++;
          $display("FAIL drop_mid_access: ready@+%0d data %h want +%0d %h",
                   cyc - s, i_data, LAT, exp_i_data);
        end
      end
    end
    n_tests++;
    if (nr != 1) begin
      n_fail++;
      $display("FAIL drop_mid_access_pulses: got %0d want 1", nr);
    end
  endtask

  task automatic test_reset_mid_access();
    int nr;
    i_req  = 1'b1;
    i_addr = 12'h008;
    @(negedge clk);             // first ACCESS cycle
    @(negedge clk);             // second ACCESS cycle
    rst   = 1'b1;
    i_req = 1'b0;
    @(negedge clk);
    model_reset();
    n_tests++;
    if (i_ready !== 1'b0 || ram_ren !== 1'b0 || i_data !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_access: i_ready %b ram_ren %b i_data %h busy %b want 0 0 0 0",
               i_ready, ram_ren, i_data, busy);
    end
    rst = 1'b0;
    nr = 0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      if (i_ready || d_ready || busy) nr++;
    end
    n_tests++;
    if (nr != 0) begin
      n_fail++;
      $display("FAIL reset_mid_access_quiet: %0d active cycles want 0", nr);
    end
  endtask

  task automatic test_random();
    bit do_f, do_d, dr, dw;
    int op;
    logic [ADDR_W-1:0] fa, da;
    for (int n = 0; n < 60; n++) begin
      do_f = 1'($urandom);
      do_d = 1'($urandom);
      if (!do_f && !do_d) do_f = 1'b1;
      op = $urandom_range(0, 2);
      dr = (op != 1);
      dw = (op != 0);
      fa = ($urandom % 2) ? ADDR_W'($urandom_range(0, 15) * 4) : ADDR_W'($urandom);
      da = ($urandom % 2) ? ADDR_W'($urandom_range(0, 15) * 4) : ADDR_W'($urandom);
      run_pair("random", do_f, fa, do_d, dr, dw, da, $urandom);
    end
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[12'h004]     = 32'h00A00093;
    ref_mem[12'h004] = 32'h00A00093;

    test_reset();
    directed_access("fetch",      1'b1, 1'b0, 1'b0, 12'h004, '0);
    directed_access("store",      1'b0, 1'b0, 1'b1, 12'h100, 32'hDEADBEEF);
    directed_access("load",       1'b0, 1'b1, 1'b0, 12'h100, '0);
    directed_access("read_write", 1'b0, 1'b1, 1'b1, 12'h010, 32'h12345678);
    test_contention();
    test_drop_mid_access();
    test_reset_mid_access();
    test_contention();
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
